osc_freq_meter: RTL
===================

// Module: osc_freq_meter
// PURPOSE
//  Parametrised N-channel gated frequency counter for the oscillator test top level.
//  Selects one of NUM_CH free-running oscillator outputs (ring oscillators, phase accumulators).
//  Counts that channel's rising edges over a fixed window of GATE_CYCLES clocks.
//  Publishes the count for the 7-seg display and for DCO characterisation.
//  Runs back-to-back measurements while enabled; latches one result per window.
// PARAMETERS
//  NUM_CH       4      number of oscillator inputs (>=2)
//  CH_W         2      channel-select width, $clog2(NUM_CH)
//  COUNT_W      16     result width; counter saturates at 2^COUNT_W-1
//  GATE_CYCLES  100000 measurement window length in fpga_clk_i cycles (1 ms at 100 MHz)
//  SYNC_STAGES  2      synchroniser depth on oscillator inputs (>=2)
// PORTS
//  fpga_clk_i   in   1        system clock (100 MHz)
//  reset_i      in   1        asynchronous, active-high reset
//  enable_i     in   1        1 = run measurements continuously
//  ch_sel_i     in   CH_W     channel to measure; values >= NUM_CH select channel 0
//  osc_i        in   NUM_CH   oscillator outputs, asynchronous to fpga_clk_i
//  count_o      out  COUNT_W  last completed measurement (edges per window)
//  valid_o      out  1        one-cycle pulse when count_o updates
//  ovf_o        out  1        last completed window saturated
//  busy_o       out  1        high in SETTLE or GATE
//  ch_o         out  CH_W     channel that count_o belongs to
// BEHAVIOUR
//  Clock and reset:
//   One clock; reset is asynchronous and active-high.
//   Reset drives: state IDLE, count_o=0, valid_o=0, ovf_o=0, busy_o=0, ch_o=0.
//   Reset also clears all synchroniser and edge-detect flops.
//  Input sampling:
//   Every osc_i bit passes through SYNC_STAGES flops, then a rising-edge detector.
//   Detector: edge = sync & ~sync_d.
//   Measurable frequency is < fpga_clk_i/2; faster sources are pre-divided upstream.
//  States:
//   IDLE   -> SETTLE when enable_i=1; ch_sel_i is captured into an internal cur_ch register.
//   SETTLE -> GATE after SYNC_STAGES+1 cycles (flushes stale synchroniser data); edge counter cleared.
//   GATE   -> LATCH after exactly GATE_CYCLES cycles.
//             Edge counter increments by 1 on each cycle where edge[cur_ch]=1.
//             The counter holds at max and sets a sticky sat flag; it never wraps.
//   LATCH  -> one cycle: count_o<=counter, ovf_o<=sat, ch_o<=cur_ch, valid_o=1.
//             Then -> SETTLE if enable_i=1 (ch_sel_i re-captured), else -> IDLE.
//  Timing:
//   First valid_o is SYNC_STAGES+1+GATE_CYCLES+1 cycles after enable_i rises in IDLE.
//   Subsequent results follow every SYNC_STAGES+GATE_CYCLES+2 cycles.
//  Boundary conditions:
//   ch_sel_i != cur_ch during SETTLE or GATE -> abort to SETTLE with the new channel; no valid_o.
//   enable_i low during SETTLE or GATE -> abort to IDLE; outputs keep the last result; no valid_o.
//   Edge detected on the final GATE cycle -> counted.
//   No edges in the window -> count_o=0, valid_o pulses.
//   reset_i mid-window -> immediate IDLE; partial count discarded.
//   busy_o is registered and follows the state (1 in SETTLE/GATE, 0 in IDLE/LATCH).
//  Width rules:
//   Gate timer width is $clog2(GATE_CYCLES+1).
//   Elaboration error if GATE_CYCLES < 1, NUM_CH < 2 or SYNC_STAGES < 2.
// STRUCTURE
//  Package osc_meter_pkg: state encoding (IDLE/SETTLE/GATE/LATCH).
//  Sub-module osc_edge_sync: per-bit synchroniser plus rising-edge detector.
//   Instantiated NUM_CH times with a generate loop.
//  Top: channel mux, gate timer, saturating edge counter, FSM, output registers.
// TESTING  (GATE_CYCLES=1000, COUNT_W=8 unless stated)
//  1. Reset mid-run: assert reset_i asynchronously -> all outputs 0 in the same cycle; IDLE after release.
//  2. ch 1 period 10 clks, enable=1 -> valid_o at cycle 1004, count_o=100, ch_o=1, ovf_o=0.
//  3. ch 2 period 2 clks (fclk/2) -> 500 edges saturate at 255 -> count_o=255, ovf_o=1.
//  4. Change ch_sel_i 0->3 at gate cycle 500 -> no valid_o; next valid_o 1004 cycles later, ch_o=3.
//  5. Drop enable_i mid-gate -> busy_o=0; count_o holds; no valid_o. Static osc -> count_o=0 with valid_o.
//  6. Continuous enable -> valid_o spacing exactly 1004 cycles; ch_sel_i=3 with NUM_CH=3 -> ch 0.

Source files
------------

// File: rtl/osc_meter_pkg.sv
// osc_meter_pkg: shared state encoding for the oscillator frequency meter
package osc_meter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    LATCH  = 2'd3
  } state_e;
endpackage

// File: rtl/osc_edge_sync.sv
// osc_edge_sync: multi-flop synchroniser followed by a rising-edge detector
module osc_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;
  // shift the raw input through the chain; keep one delayed copy of the synced level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], osc_i};
    dly_d  = sync_q[STAGES-1];
  end
  // synchroniser and detector flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
endmodule

// File: rtl/osc_freq_meter.sv
// osc_freq_meter: gated edge counter measuring one of NUM_CH asynchronous oscillators
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int COUNT_W     = 16,
  parameter int GATE_CYCLES = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               fpga_clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [CH_W-1:0]    ch_sel_i,
  input  logic [NUM_CH-1:0]  osc_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               valid_o,
  output logic               ovf_o,
  output logic               busy_o,
  output logic [CH_W-1:0]    ch_o
);
  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  if (GATE_CYCLES < 1 || NUM_CH < 2 || SYNC_STAGES < 2) begin : g_param_err
    $error("osc_freq_meter: need GATE_CYCLES>=1, NUM_CH>=2, SYNC_STAGES>=2");
  end

  logic [NUM_CH-1:0]  rise;
  logic [CH_W-1:0]    sel_ch;
  logic               edge_sel;
  logic [COUNT_W-1:0] cnt_inc;
  logic               sat_inc;
  state_e             state_q, state_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d, ch_q, ch_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [TW-1:0]      gate_q, gate_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
  logic               sat_q, sat_d, valid_q, valid_d, ovf_q, ovf_d, busy_q, busy_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    osc_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (fpga_clk_i),
      .rst    (reset_i),
      .osc_i  (osc_i[i]),
      .rise_o (rise[i])
    );
  end

  // out-of-range selects fall back to channel 0
  assign sel_ch   = (32'(ch_sel_i) < NUM_CH) ? ch_sel_i : '0;
  assign edge_sel = rise[cur_ch_q];
  // saturating increment; sat records an edge that arrived with the counter already full
  assign cnt_inc  = (edge_sel && cnt_q != CNT_MAX) ? cnt_q + COUNT_W'(1) : cnt_q;
  assign sat_inc  = sat_q | (edge_sel && cnt_q == CNT_MAX);

  // next-state, timers, counter and result registers
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ch_d     = ch_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d  = SETTLE;
          cur_ch_d = sel_ch;
          settle_d = '0;
        end
      end
      SETTLE, GATE: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (sel_ch != cur_ch_q) begin
          state_d  = SETTLE;
          cur_ch_d = sel_ch;
          settle_d = '0;
        end else if (state_q == SETTLE) begin
          settle_d = settle_q + SW'(1);
          cnt_d    = '0;
          sat_d    = 1'b0;
          gate_d   = '0;
          state_d  = (settle_q == SW'(SYNC_STAGES)) ? GATE : SETTLE;
        end else begin
          cnt_d  = cnt_inc;
          sat_d  = sat_inc;
          gate_d = gate_q + TW'(1);
          if (gate_q == TW'(GATE_CYCLES - 1)) begin
            state_d = LATCH;
            count_d = cnt_inc;
            ovf_d   = sat_inc;
            ch_d    = cur_ch_q;
            valid_d = 1'b1;
          end
        end
      end
      LATCH: begin
        state_d = enable_i ? SETTLE : IDLE;
        if (enable_i) begin
          cur_ch_d = sel_ch;
          settle_d = '0;
        end
      end
    endcase
    busy_d = (state_d == SETTLE) || (state_d == GATE);
  end

  // single register bank for FSM state and all outputs
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cur_ch_q <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = busy_q;
  assign ch_o    = ch_q;
endmodule
